// File: rtl/sr_pkg.sv
// Shared constants for the sr_ff_bank flag register bank and its per-channel cell.
package sr_pkg;

  // Conflict policy applied when both set and reset requests are active
  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_SET_DOM = 2'b01;
  localparam logic [1:0] MODE_RST_DOM = 2'b10;
  localparam logic [1:0] MODE_TOGGLE  = 2'b11;

  // Largest supported channel count
  localparam int SR_MAX_WIDTH = 32;

endpackage

// File: rtl/sr_cell.sv
// One SR storage channel: optional input synchroniser, set/reset decode with
// selectable conflict policy, change pulse and sticky conflict flag.
module sr_cell
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_n,
  input  logic       r_n,
  input  logic [1:0] mode,
  input  logic       clr_err,
  input  logic       init_val,
  output logic       q,
  output logic       changed,
  output logic       conflict
);

  logic s_smp;
  logic r_smp;

  logic q_d, q_q;
  logic changed_d, changed_q;
  logic conflict_d, conflict_q;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_smp = s_n;
    assign r_smp = r_n;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] s_sync_d, s_sync_q;
    logic [SYNC_STAGES-1:0] r_sync_d, r_sync_q;

    // Shift the raw requests one stage deeper each clock, newest sample in bit 0
    always_comb begin
      s_sync_d    = s_sync_q << 1;
      r_sync_d    = r_sync_q << 1;
      s_sync_d[0] = s_n;
      r_sync_d[0] = r_n;
    end

    // Synchroniser flops idle at 1 so reset never looks like a request
    always_ff @(posedge clk) begin
      if (rst) begin
        s_sync_q <= '1;
        r_sync_q <= '1;
      end else begin
        s_sync_q <= s_sync_d;
        r_sync_q <= r_sync_d;
      end
    end

    assign s_smp = s_sync_q[SYNC_STAGES-1];
    assign r_smp = r_sync_q[SYNC_STAGES-1];
  end

  // Decode next state; a new conflict outranks clr_err at the same edge
  always_comb begin
    q_d        = q_q;
    conflict_d = clr_err ? 1'b0 : conflict_q;
    case ({s_smp, r_smp})
      2'b01: q_d = 1'b1;
      2'b10: q_d = 1'b0;
      2'b00: begin
        conflict_d = 1'b1;
        case (mode)
          MODE_HOLD:    q_d = q_q;
          MODE_SET_DOM: q_d = 1'b1;
          MODE_RST_DOM: q_d = 1'b0;
          default:      q_d = ~q_q;
        endcase
      end
      default: q_d = q_q;
    endcase
    changed_d = q_d ^ q_q;
  end

  // State, change pulse and sticky flag; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= init_val;
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      changed_q  <= changed_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign changed  = changed_q;
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent clocked SR flags sharing one conflict policy.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 0,
  parameter logic [WIDTH-1:0] INIT        = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_n,
  input  logic [WIDTH-1:0] r_n,
  input  logic [1:0]       mode,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_any
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sr_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .s_n      (s_n[i]),
      .r_n      (r_n[i]),
      .mode     (mode),
      .clr_err  (clr_err),
      .init_val (INIT[i]),
      .q        (q[i]),
      .changed  (changed[i]),
      .conflict (conflict[i])
    );
  end

  // Complement and summary flag come straight from the registers, no extra latency
  assign qn           = ~q;
  assign conflict_any = |conflict;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: two instances (unsynchronised INIT=A5, two-stage sync INIT=00)
// driven by the same stimulus and compared every cycle against a queue-fed model.
module tb_sr_ff_bank;
  import sr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s_n = 8'hFF;
  logic [7:0] r_n = 8'hFF;
  logic [1:0] mode = MODE_HOLD;
  logic       clr_err = 1'b0;

  logic [7:0] q0, qn0, ch0, cf0;
  logic [7:0] q1, qn1, ch1, cf1;
  logic       any0, any1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] ch;
    logic [7:0] cf;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  // Reference state
  logic [7:0] mq[2];
  logic [7:0] mch[2];
  logic [7:0] mcf[2];
  logic [7:0] ps1[$];
  logic [7:0] pr1[$];
  logic [7:0] minit[2] = '{8'hA5, 8'h00};

  sr_ff_bank #(.WIDTH(8), .SYNC_STAGES(0), .INIT(8'hA5)) dut0 (
    .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .mode(mode), .clr_err(clr_err),
    .q(q0), .qn(qn0), .changed(ch0), .conflict(cf0), .conflict_any(any0)
  );

  sr_ff_bank #(.WIDTH(8), .SYNC_STAGES(2), .INIT(8'h00)) dut1 (
    .clk(clk), .rst(rst), .s_n(s_n), .r_n(r_n), .mode(mode), .clr_err(clr_err),
    .q(q1), .qn(qn1), .changed(ch1), .conflict(cf1), .conflict_any(any1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: requests seen after a delay line of k stages, then the SR rules
  task automatic model_step(input int k, input logic [7:0] s, input logic [7:0] r,
                            input logic [1:0] m, input logic clr, input logic rs);
    logic [7:0] es, er, nq, ncf;
    if (rs) begin
      mq[k]  = minit[k];
      mch[k] = 8'h00;
      mcf[k] = 8'h00;
      if (k == 1) begin
        ps1.delete(); pr1.delete();
        repeat (2) begin ps1.push_back(8'hFF); pr1.push_back(8'hFF); end
      end
    end else begin
      if (k == 0) begin
        es = s; er = r;
      end else begin
        es = ps1.pop_front(); er = pr1.pop_front();
        ps1.push_back(s); pr1.push_back(r);
      end
      nq = mq[k];
      for (int i = 0; i < 8; i++) begin
        if (!es[i] && er[i])      nq[i] = 1'b1;
        else if (es[i] && !er[i]) nq[i] = 1'b0;
        else if (!es[i] && !er[i]) begin
          if (m == 2'd1)      nq[i] = 1'b1;
          else if (m == 2'd2) nq[i] = 1'b0;
          else if (m == 2'd3) nq[i] = ~mq[k][i];
        end
      end
      ncf    = (clr ? 8'h00 : mcf[k]) | (~es & ~er);
      mch[k] = nq ^ mq[k];
      mq[k]  = nq;
      mcf[k] = ncf;
    end
  endtask

  // Apply one cycle of stimulus, advance the model, and queue the post-edge expectation
  task automatic step(input logic [7:0] s, input logic [7:0] r, input logic [1:0] m,
                      input logic clr, input logic rs);
    s_n = s; r_n = r; mode = m; clr_err = clr; rst = rs;
    model_step(0, s, r, m, clr, rs);
    model_step(1, s, r, m, clr, rs);
    @(posedge clk);
    sb0.push_back('{q: mq[0], ch: mch[0], cf: mcf[0]});
    sb1.push_back('{q: mq[1], ch: mch[1], cf: mcf[1]});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'hFF, 8'hFF, mode, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle after an edge, pop and compare both instances
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        chk("sb0_q", q0, e.q);
        chk("sb0_qn", qn0, ~e.q);
        chk("sb0_changed", ch0, e.ch);
        chk("sb0_conflict", cf0, e.cf);
        chk("sb0_conflict_any", {7'd0, any0}, {7'd0, |e.cf});
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        chk("sb1_q", q1, e.q);
        chk("sb1_qn", qn1, ~e.q);
        chk("sb1_changed", ch1, e.ch);
        chk("sb1_conflict", cf1, e.cf);
        chk("sb1_conflict_any", {7'd0, any1}, {7'd0, |e.cf});
      end
    end
  end

  logic [7:0] tog_exp [4][3] = '{'{8'h1, 8'h1, 8'h1}, '{8'h1, 8'h1, 8'h1},
                                 '{8'h0, 8'h0, 8'h0}, '{8'h0, 8'h1, 8'h0}};

  initial begin
    logic [7:0] rs_, rr_;
    // Reset
    step(8'hFF, 8'hFF, MODE_HOLD, 1'b0, 1'b1);
    step(8'hFF, 8'hFF, MODE_HOLD, 1'b0, 1'b1);
    chk("reset_q", q0, 8'hA5);
    chk("reset_qn", qn0, 8'h5A);
    chk("reset_changed", ch0, 8'h00);
    chk("reset_conflict", cf0, 8'h00);
    chk("reset_q_sync", q1, 8'h00);
    idle(1);

    // Basic set/reset on channel 0 (clear everything first)
    step(8'hFF, 8'h00, MODE_HOLD, 1'b0, 1'b0);
    idle(3);
    step(8'hFE, 8'hFF, MODE_HOLD, 1'b0, 1'b0);
    chk("set_q", q0, 8'h01);
    chk("set_changed", ch0, 8'h01);
    step(8'hFF, 8'hFE, MODE_HOLD, 1'b0, 1'b0);
    chk("rst_q", q0, 8'h00);
    chk("rst_changed", ch0, 8'h01);
    step(8'hFE, 8'hFF, MODE_HOLD, 1'b0, 1'b0);
    step(8'hFE, 8'hFF, MODE_HOLD, 1'b0, 1'b0);
    chk("reset_again_changed", ch0, 8'h00);
    chk("reset_again_q", q0, 8'h01);

    // Conflict policies, ch0 starts at 1 with a clean flag
    for (int m = 0; m < 4; m++) begin
      step(8'hFE, 8'hFF, 2'(m), 1'b0, 1'b0);
      step(8'hFF, 8'hFF, 2'(m), 1'b1, 1'b0);
      idle(2);
      for (int c = 0; c < 3; c++) begin
        step(8'hFE, 8'hFE, 2'(m), 1'b0, 1'b0);
        chk($sformatf("conf_m%0d_c%0d_q0", m, c), {7'd0, q0[0]}, tog_exp[m][c]);
        chk($sformatf("conf_m%0d_c%0d_flag", m, c), {6'd0, any0, cf0[0]}, 8'h03);
      end
      idle(3);
    end

    // Sticky flag: clear while idle, then clear colliding with a new conflict
    step(8'hFF, 8'hFF, MODE_HOLD, 1'b1, 1'b0);
    chk("clr_err_idle", cf0, 8'h00);
    step(8'hFE, 8'hFE, MODE_HOLD, 1'b1, 1'b0);
    chk("clr_err_vs_conflict", cf0, 8'h01);
    idle(3);

    // Latency through the two-stage synchroniser on channel 3
    step(8'hFF, 8'h00, MODE_HOLD, 1'b0, 1'b0);
    idle(3);
    step(8'hF7, 8'hFF, MODE_HOLD, 1'b0, 1'b0);
    chk("lat_c1", q1 & 8'h08, 8'h00);
    step(8'hF7, 8'hFF, MODE_HOLD, 1'b0, 1'b0);
    chk("lat_c2", q1 & 8'h08, 8'h00);
    step(8'hF7, 8'hFF, MODE_HOLD, 1'b0, 1'b0);
    chk("lat_c3", q1 & 8'h08, 8'h08);
    idle(3);

    // Reset in the middle of an active toggle conflict
    step(8'hFE, 8'hFE, MODE_TOGGLE, 1'b0, 1'b0);
    step(8'hFE, 8'hFE, MODE_TOGGLE, 1'b0, 1'b0);
    step(8'hFE, 8'hFE, MODE_TOGGLE, 1'b0, 1'b1);
    chk("midrst_q", q0, 8'hA5);
    chk("midrst_conflict", cf0, 8'h00);
    chk("midrst_changed", ch0, 8'h00);
    step(8'hFE, 8'hFE, MODE_TOGGLE, 1'b0, 1'b0);
    chk("resume_q", q0, 8'hA4);
    chk("resume_changed", ch0, 8'h01);
    idle(3);

    // Randomised traffic: mostly idle bits, some set/reset/conflict, rare clr/rst
    for (int n = 0; n < 400; n++) begin
      rs_ = 8'($urandom) | 8'($urandom);
      rr_ = 8'($urandom) | 8'($urandom);
      step(rs_, rr_, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d/%0d expected=0/0", sb0.size(), sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
